// File: rtl/sm_sched.sv
// sm_sched -- eight-channel sample scheduler with an fx-bus register block.
//
// Each channel strobes a 16-bit smoothed sample into its own hold register.
// A round-robin arbiter moves pending samples into a single output register
// that drains through a valid/ready handshake. Samples that arrive while a
// channel is still pending overwrite the older value.
//
// Ports
//   clk_sys              system clock, rising edge
//   rst                  synchronous active-high reset
//   smN_data / smN_vld   per-channel sample and one-cycle strobe (N = 1..8)
//   out_data/out_ch/out_vld, out_rdy   scheduled output handshake
//   fx_waddr/fx_wr/fx_data             register write port
//   fx_raddr/fx_rd/fx_q                register read port (fx_q registered)
//   dev_id               device select, compared against addr[21:16]
//
// Register map (offset = addr[7:0])
//   0x00 EN   RW   channel enable mask, bit n = channel n+1
//   0x01 OVF  R/W1C sticky overrun flags
//   0x02 PEND RO   channels holding an undelivered sample
//
// Build option
//   SM_SCHED_OVF_EN  defined: overrun flags implemented.
//                    undefined: 0x01 reads 0x00 and writes are dropped.

module sm_sched (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [15:0] sm1_data,
  input  logic [15:0] sm2_data,
  input  logic [15:0] sm3_data,
  input  logic [15:0] sm4_data,
  input  logic [15:0] sm5_data,
  input  logic [15:0] sm6_data,
  input  logic [15:0] sm7_data,
  input  logic [15:0] sm8_data,
  input  logic        sm1_vld,
  input  logic        sm2_vld,
  input  logic        sm3_vld,
  input  logic        sm4_vld,
  input  logic        sm5_vld,
  input  logic        sm6_vld,
  input  logic        sm7_vld,
  input  logic        sm8_vld,
  output logic [15:0] out_data,
  output logic [2:0]  out_ch,
  output logic        out_vld,
  input  logic        out_rdy,
  input  logic [21:0] fx_waddr,
  input  logic [21:0] fx_raddr,
  input  logic        fx_wr,
  input  logic        fx_rd,
  input  logic [7:0]  fx_data,
  output logic [7:0]  fx_q,
  input  logic [5:0]  dev_id
);

  logic [15:0] sm_data [8];
  logic [7:0]  sm_vld;

  assign sm_data[0] = sm1_data;
  assign sm_data[1] = sm2_data;
  assign sm_data[2] = sm3_data;
  assign sm_data[3] = sm4_data;
  assign sm_data[4] = sm5_data;
  assign sm_data[5] = sm6_data;
  assign sm_data[6] = sm7_data;
  assign sm_data[7] = sm8_data;
  assign sm_vld = {sm8_vld, sm7_vld, sm6_vld, sm5_vld,
                   sm4_vld, sm3_vld, sm2_vld, sm1_vld};

  logic [7:0]  en_q;
  logic [7:0]  pend_q;
  logic [7:0]  ovf_q;
  logic [15:0] hold_q [8];
  logic [2:0]  ptr_q;

  // Address bits 15:8 do not take part in decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{fx_waddr[15:8], fx_raddr[15:8]};

  logic wsel, rsel, wr_en;
  assign wsel  = fx_wr && (fx_waddr[21:16] == dev_id);
  assign rsel  = fx_rd && (fx_raddr[21:16] == dev_id);
  assign wr_en = wsel && (fx_waddr[7:0] == 8'h00);

  logic [7:0] cap;
  assign cap = sm_vld & en_q;

  // Output register can take a new word when empty or being drained now.
  logic load_ok;
  assign load_ok = !out_vld || out_rdy;

  // Round-robin: first pending channel after the last granted one.
  logic       gnt_vld;
  logic [2:0] gnt_idx;
  logic [2:0] cand;
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    cand    = ptr_q;
    for (int i = 1; i <= 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!gnt_vld && pend_q[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  logic       take;
  logic [7:0] gnt_oh;
  assign take   = gnt_vld && load_ok;
  assign gnt_oh = take ? (8'h01 << gnt_idx) : 8'h00;

  logic [7:0] en_next;
  logic [7:0] pend_next;
  assign en_next = wr_en ? fx_data : en_q;
  // A capture on the granted channel re-arms PEND; a disabled channel is
  // dropped as soon as the new mask lands.
  assign pend_next = ((pend_q & ~gnt_oh) | cap) & en_next;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      en_q     <= 8'hFF;
      pend_q   <= 8'h00;
      ptr_q    <= 3'd7;
      out_vld  <= 1'b0;
      out_data <= 16'h0000;
      out_ch   <= 3'd0;
      for (int i = 0; i < 8; i++) hold_q[i] <= 16'h0000;
    end else begin
      en_q   <= en_next;
      pend_q <= pend_next;
      for (int i = 0; i < 8; i++) begin
        if (cap[i]) hold_q[i] <= sm_data[i];
      end
      if (load_ok) begin
        out_vld <= gnt_vld;
        if (gnt_vld) begin
          // hold_q still carries the pre-capture value this cycle.
          out_data <= hold_q[gnt_idx];
          out_ch   <= gnt_idx;
          ptr_q    <= gnt_idx;
        end
      end
    end
  end

`ifdef SM_SCHED_OVF_EN
  logic       wr_ovf;
  logic [7:0] ovf_set;
  assign wr_ovf  = wsel && (fx_waddr[7:0] == 8'h01);
  assign ovf_set = cap & pend_q & ~gnt_oh;

  // Set has priority over a same-cycle write-1-clear.
  always_ff @(posedge clk_sys) begin
    if (rst) ovf_q <= 8'h00;
    else     ovf_q <= (ovf_q & ~(wr_ovf ? fx_data : 8'h00)) | ovf_set;
  end
`else
  assign ovf_q = 8'h00;
`endif

  logic [7:0] rd_mux;
  always_comb begin
    rd_mux = 8'h00;
    case (fx_raddr[7:0])
      8'h00:   rd_mux = en_q;
      8'h01:   rd_mux = ovf_q;
      8'h02:   rd_mux = pend_q;
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) fx_q <= 8'h00;
    else     fx_q <= rsel ? rd_mux : 8'h00;
  end

endmodule

// File: doc/sm_sched.md
SM_SCHED -- requirements
Module: sm_sched

Interface
REQ-001 clk_sys  input  1  system clock; all logic rising-edge.
REQ-002 rst  input  1  synchronous active-high reset.
REQ-003 sm1_data..sm8_data  input  16 each  per-channel smoothed sample.
REQ-004 sm1_vld..sm8_vld  input  1 each  one-cycle sample strobe per channel.
REQ-005 out_data  output  16  scheduled sample.
REQ-006 out_ch  output  3  source channel of out_data (0 = ch1 … 7 = ch8).
REQ-007 out_vld  output  1  out_data/out_ch valid.
REQ-008 out_rdy  input  1  consumer accepts when out_vld && out_rdy.
REQ-009 fx_waddr, fx_raddr  input  22  fx bus addresses.
REQ-010 fx_wr, fx_rd  input  1  fx bus one-cycle write/read strobes.
REQ-011 fx_data  input  8  fx write data.
REQ-012 fx_q  output  8  fx read data.
REQ-013 dev_id  input  6  device select.

Function
REQ-014 Selection: selected when addr[21:16]==dev_id; register offset = addr[7:0]; other offsets write-ignored, read 0x00.
REQ-015 Registers: 0x00 EN mask (RW, bit n = ch n+1); 0x01 OVF sticky (read; write-1-clear); 0x02 PEND (RO).
REQ-016 fx_q registered: valid cycle after fx_rd; 0x00 when not selected or no read.
REQ-017 Capture: smN_vld && EN[n] at edge t -> hold register loads sm data, PEND[n] set, visible from t+1.
REQ-018 smN_vld with EN[n]=0 is ignored; no PEND, no OVF.
REQ-019 Overrun: vld while PEND[n] set and not granted same cycle -> hold overwritten with newest data, OVF[n] set.
REQ-020 Vld on same cycle channel n is granted -> granted value goes to output, new value captured, PEND stays set, no OVF.
REQ-021 Output register empty or accepted this cycle (out_vld && out_rdy) -> load next pending channel; else hold out_data/out_ch/out_vld stable.
REQ-022 Grant is round-robin: search starts at channel after last granted, wraps 7->0; last-granted pointer resets to 7.
REQ-023 Grant clears that channel's PEND (unless REQ-020 applies) and updates pointer.
REQ-024 Latency: isolated sample, idle output, out_rdy=1 -> out_vld asserted 2 cycles after smN_vld.
REQ-025 Throughput: one sample per cycle while out_rdy=1 and pending work exists.
REQ-026 Clearing EN[n] via fx write discards PEND[n] next cycle; in-flight output sample is still delivered.
REQ-027 fx write to OVF in the same cycle as a new overrun on that bit -> bit remains set (set wins).

Reset
REQ-028 rst: out_vld=0, out_data=0, out_ch=0, fx_q=0, PEND=0, OVF=0, EN=0xFF, pointer=7, hold registers=0.
REQ-029 rst mid-transfer aborts the held output word; no sample is delivered from before reset.

Configuration
REQ-030 Macro SM_SCHED_OVF_EN: defined -> OVF register and overrun detection as in REQ-015/019/027.
REQ-031 Undefined -> OVF logic absent, offset 0x01 reads 0x00, writes ignored; overwrite behaviour of REQ-019 unchanged.

Verification
REQ-032 Reset, then read 0x00 -> fx_q=0xFF; read 0x02 -> 0x00; out_vld=0.
REQ-033 All 8 vld in one cycle, data 0x1000+n, out_rdy=1 -> 8 consecutive words, out_ch 0..7 in order, out_vld from +2.
REQ-034 out_rdy=0 with ch3 and ch5 pending -> output frozen on ch3; second ch5 vld sets OVF bit4; after release ch5 delivers newest value.
REQ-035 EN=0x01, vld on all channels -> only ch1 delivered; PEND=0x01 then 0x00.
REQ-036 OVF=0x10, write 0x10 to 0x01 -> reads 0x00; repeat with simultaneous overrun -> stays 0x10 (macro defined only).
REQ-037 rst asserted while out_vld=1 && out_rdy=0 -> out_vld=0 next cycle; no stale word after reset release.
